clock_timekeeper_ctrl: RTL

Timekeeping controller for the digital clock. It divides the board clock into a single-cycle 1 Hz enable tick and uses it to advance hour, minute and second counters. A mode/increment button state machine lets the user stop the clock and set each field. A free-running blink enable drives the display flashing for the field being edited. It sits between the debounced button logic and the 7-segment display driver, replacing the divided-clock approach with a single-clock-domain enable scheme.

---
 rtl/clock_timekeeper_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/clock_timekeeper_ctrl.sv
// Timekeeping controller: divides i_clk into a 1-cycle time-advance enable,
// maintains hh:mm:ss, runs the mode/increment set FSM and a free-running blink.
module clock_timekeeper_ctrl #(
    parameter int SOURCE_CLOCK = 100000000,
    parameter int TICK_HZ      = 1,
    parameter int BLINK_HZ     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_mode,
    input  logic       i_inc,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic [1:0] o_state,
    output logic       o_tick,
    output logic       o_blink
);
    localparam int DIV  = SOURCE_CLOCK / TICK_HZ;
    localparam int HALF = SOURCE_CLOCK / (2 * BLINK_HZ);
    localparam int PW   = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [4:0]      hour_q, hour_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic            tick_q, tick_d;
    logic            blink_q, blink_d;
    logic            adv;

    always_comb begin
        adv         = (state_q == RUN) && (presc_q == PW'(DIV - 1));
        presc_d     = presc_q;
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;

        // Prescaler parks at 0 outside RUN so resuming gives a full period.
        if (state_q != RUN || adv) presc_d = '0;
        else                       presc_d = presc_q + 1'b1;

        // A tick coincident with a mode press still advances, but the pulse is
        // suppressed so o_tick is never seen high outside RUN.
        tick_d = adv && !i_mode;

        if (i_mode) state_d = state_t'(state_q + 2'd1);

        if (adv) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d  = '0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (i_inc && !i_mode) begin
            case (state_q)
                SET_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                SET_MIN:  min_d  = (min_q  == 6'd59) ? 6'd0 : min_q + 6'd1;
                SET_SEC:  sec_d  = (sec_q  == 6'd59) ? 6'd0 : sec_q + 6'd1;
                default:  ;
            endcase
        end

        if (blink_cnt_q == BW'(HALF - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            tick_q      <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            tick_q      <= tick_d;
            blink_q     <= blink_d;
        end
    end

    assign o_hour  = hour_q;
    assign o_min   = min_q;
    assign o_sec   = sec_q;
    assign o_state = state_q;
    assign o_tick  = tick_q;
    assign o_blink = blink_q;
endmodule
